// File: rtl/uart_pkg.sv
// Shared definitions for the Avalon-MM UART: register addresses, STATUS/CTRL bit
// positions and the TX/RX state encodings.
package uart_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  localparam int ST_RX_NEMPTY  = 0;
  localparam int ST_TX_FULL    = 1;
  localparam int ST_TX_IDLE    = 2;
  localparam int ST_FRAME_ERR  = 3;
  localparam int ST_OVERRUN    = 4;
  localparam int ST_PARITY_ERR = 5;

  localparam int CT_IE_RX      = 0;
  localparam int CT_IE_TX      = 1;
  localparam int CT_PARITY_ODD = 2;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

endpackage

// File: rtl/uart_fifo_buf.sv
// Synchronous first-word-fall-through FIFO; a push and a pop in the same cycle
// both succeed even when full or empty (empty case passes din straight through).
module uart_fifo_buf #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          push_ok, pop_ok;

  assign full    = (count_reg == DEPTH_CNT);
  assign empty   = (count_reg == '0);
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & (~empty | push);
  assign dout    = empty ? din : mem[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_fifo.sv
// Avalon-MM UART with TX/RX FIFOs, interrupt enables and sticky error flags.
// Optional parity bit: define UART_FIFO_PARITY_EN.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int CPB   = 2500,
  parameter int DW    = 8,
  parameter int TX_AW = 3,
  parameter int RX_AW = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        avalon_read,
  input  logic        avalon_write,
  input  logic [1:0]  avalon_address,
  input  logic [1:0]  avalon_byteenable,
  input  logic [15:0] avalon_writedata,
  output logic [15:0] avalon_readdata,
  output logic        avalon_waitrequest,
  output logic        status_irq,
  output logic        status_err,
  input  logic        uart_rxd,
  output logic        uart_txd
);

  localparam int CW = $clog2(CPB);
  localparam int BW = $clog2(DW);
  localparam logic [CW-1:0] BIT_END  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CPB / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DW - 1);
  localparam logic [TX_AW:0] TX_ONE  = (TX_AW+1)'(1);

  logic [DW-1:0]  tx_dout, rx_dout;
  logic           tx_push, tx_pop, tx_full, tx_empty, tx_idle;
  logic           rx_push, rx_pop, rx_full, rx_empty;
  logic [TX_AW:0] tx_count;
  logic [RX_AW:0] rx_count;
  logic           ie_rx_reg, ie_tx_reg, parity_odd, irq_reg;
  logic           frame_err_reg, overrun_reg, parity_err_reg;
  logic           frame_set, overrun_set, parity_set;
  logic           data_wr, status_wr;
  logic [15:0]    rd_word, readdata_reg;
  logic           unused_bits;

  assign unused_bits = ^{avalon_byteenable, avalon_writedata};

  // ---------------- Avalon side ----------------
  assign data_wr            = avalon_write && (avalon_address == ADDR_DATA);
  assign status_wr          = avalon_write && (avalon_address == ADDR_STATUS);
  assign avalon_waitrequest = data_wr & tx_full & ~tx_pop;
  assign tx_push            = data_wr & ~avalon_waitrequest;
  assign rx_pop             = avalon_read && (avalon_address == ADDR_DATA) && !rx_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ie_rx_reg <= 1'b0;
      ie_tx_reg <= 1'b0;
    end else if (avalon_write && avalon_address == ADDR_CTRL) begin
      ie_rx_reg <= avalon_writedata[CT_IE_RX];
      ie_tx_reg <= avalon_writedata[CT_IE_TX];
    end
  end

`ifdef UART_FIFO_PARITY_EN
  logic parity_odd_reg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_odd_reg <= 1'b0;
    else if (avalon_write && avalon_address == ADDR_CTRL)
      parity_odd_reg <= avalon_writedata[CT_PARITY_ODD];
  end
  assign parity_odd = parity_odd_reg;
`else
  assign parity_odd = 1'b0;
`endif

  // Sticky flags: a set in the same cycle as a write-1-to-clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err_reg  <= 1'b0;
      overrun_reg    <= 1'b0;
      parity_err_reg <= 1'b0;
      irq_reg        <= 1'b0;
      readdata_reg   <= '0;
    end else begin
      frame_err_reg  <= frame_set   | (frame_err_reg  & ~(status_wr & avalon_writedata[ST_FRAME_ERR]));
      overrun_reg    <= overrun_set | (overrun_reg    & ~(status_wr & avalon_writedata[ST_OVERRUN]));
      parity_err_reg <= parity_set  | (parity_err_reg & ~(status_wr & avalon_writedata[ST_PARITY_ERR]));
      irq_reg        <= (ie_rx_reg & ~rx_empty) | (ie_tx_reg & tx_idle);
      if (avalon_read) readdata_reg <= rd_word;
    end
  end

  always_comb begin
    rd_word = '0;
    case (avalon_address)
      ADDR_DATA:   if (!rx_empty) rd_word[DW-1:0] = rx_dout;
      ADDR_STATUS: rd_word = {8'(rx_count), 2'b00, parity_err_reg, overrun_reg,
                              frame_err_reg, tx_idle, tx_full, ~rx_empty};
      ADDR_CTRL:   rd_word = {13'd0, parity_odd, ie_tx_reg, ie_rx_reg};
      default:     rd_word = '0;
    endcase
  end

  assign avalon_readdata = readdata_reg;
  assign status_irq      = irq_reg;
  assign status_err      = frame_err_reg | overrun_reg | parity_err_reg;

  uart_fifo_buf #(.DW(DW), .AW(TX_AW)) u_tx_buf (
    .clk(clk), .rst(rst), .push(tx_push), .din(avalon_writedata[DW-1:0]), .pop(tx_pop),
    .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  // ---------------- TX ----------------
  // The byte being sent stays at the FIFO head until its stop bit ends.
  tx_state_t     tx_state_reg, tx_state_next;
  logic [CW-1:0] tx_cnt_reg;
  logic [BW-1:0] tx_bit_reg;
  logic          tx_tick, txd_reg, txd_next;

  assign tx_tick  = (tx_cnt_reg == BIT_END);
  assign tx_idle  = tx_empty && (tx_state_reg == TX_IDLE);
  assign uart_txd = txd_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_reg <= TX_IDLE;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
      txd_reg      <= 1'b1;
    end else begin
      tx_state_reg <= tx_state_next;
      txd_reg      <= txd_next;
      tx_cnt_reg   <= (tx_state_reg == TX_IDLE || tx_tick) ? '0 : tx_cnt_reg + CW'(1);
      if (tx_state_reg == TX_START) tx_bit_reg <= '0;
      else if (tx_state_reg == TX_DATA && tx_tick) tx_bit_reg <= tx_bit_reg + BW'(1);
    end
  end

  always_comb begin
    tx_state_next = tx_state_reg;
    case (tx_state_reg)
      TX_IDLE:  if (!tx_empty) tx_state_next = TX_START;
      TX_START: if (tx_tick) tx_state_next = TX_DATA;
      TX_DATA:
        if (tx_tick && tx_bit_reg == LAST_BIT)
`ifdef UART_FIFO_PARITY_EN
          tx_state_next = TX_PARITY;
`else
          tx_state_next = TX_STOP;
`endif
      TX_PARITY: if (tx_tick) tx_state_next = TX_STOP;
      TX_STOP:
        if (tx_tick) tx_state_next = (tx_count > TX_ONE || tx_push) ? TX_START : TX_IDLE;
      default:  tx_state_next = TX_IDLE;
    endcase
  end

  always_comb begin
    txd_next = 1'b1;
    tx_pop   = 1'b0;
    case (tx_state_reg)
      TX_START:  txd_next = 1'b0;
      TX_DATA:   txd_next = tx_dout[tx_bit_reg];
      TX_PARITY: txd_next = (^tx_dout) ^ parity_odd;
      TX_STOP:   tx_pop   = tx_tick;
      default:   txd_next = 1'b1;
    endcase
  end

  // ---------------- RX ----------------
  rx_state_t     rx_state_reg, rx_state_next;
  logic [1:0]    rxd_sync_reg;
  logic          rxd_prev_reg, rxd_s, rx_sample;
  logic [CW-1:0] rx_cnt_reg;
  logic [BW-1:0] rx_bit_reg;
  logic [DW-1:0] rx_shift_reg;

  assign rxd_s     = rxd_sync_reg[1];
  assign rx_sample = (rx_state_reg == RX_START) ? (rx_cnt_reg == HALF_END) : (rx_cnt_reg == BIT_END);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_reg <= RX_IDLE;
      rxd_sync_reg <= 2'b11;
      rxd_prev_reg <= 1'b1;
      rx_cnt_reg   <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
    end else begin
      rx_state_reg <= rx_state_next;
      rxd_sync_reg <= {rxd_sync_reg[0], uart_rxd};
      rxd_prev_reg <= rxd_s;
      rx_cnt_reg   <= (rx_state_reg == RX_IDLE || rx_sample) ? '0 : rx_cnt_reg + CW'(1);
      if (rx_state_reg == RX_START) rx_bit_reg <= '0;
      else if (rx_state_reg == RX_DATA && rx_sample) begin
        rx_shift_reg <= {rxd_s, rx_shift_reg[DW-1:1]};
        rx_bit_reg   <= rx_bit_reg + BW'(1);
      end
    end
  end

`ifdef UART_FIFO_PARITY_EN
  logic rx_par_bad_reg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_par_bad_reg <= 1'b0;
    else if (rx_state_reg == RX_START) rx_par_bad_reg <= 1'b0;
    else if (rx_state_reg == RX_PARITY && rx_sample)
      rx_par_bad_reg <= rxd_s ^ (^rx_shift_reg) ^ parity_odd;
  end
  assign parity_set = rx_push & rx_par_bad_reg;
`else
  assign parity_set = 1'b0;
`endif

  always_comb begin
    rx_state_next = rx_state_reg;
    case (rx_state_reg)
      RX_IDLE:  if (rxd_prev_reg && !rxd_s) rx_state_next = RX_START;
      RX_START: if (rx_sample) rx_state_next = rxd_s ? RX_IDLE : RX_DATA;
      RX_DATA:
        if (rx_sample && rx_bit_reg == LAST_BIT)
`ifdef UART_FIFO_PARITY_EN
          rx_state_next = RX_PARITY;
`else
          rx_state_next = RX_STOP;
`endif
      RX_PARITY: if (rx_sample) rx_state_next = RX_STOP;
      RX_STOP:   if (rx_sample) rx_state_next = RX_IDLE;
      default:   rx_state_next = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_push   = 1'b0;
    frame_set = 1'b0;
    if (rx_state_reg == RX_STOP && rx_sample) begin
      rx_push   = rxd_s;
      frame_set = ~rxd_s;
    end
  end

  assign overrun_set = rx_push & rx_full & ~rx_pop;

  uart_fifo_buf #(.DW(DW), .AW(RX_AW)) u_rx_buf (
    .clk(clk), .rst(rst), .push(rx_push), .din(rx_shift_reg), .pop(rx_pop),
    .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

endmodule

// File: tb/tb_uart_fifo.sv
// Scoreboard bench for uart_fifo: Avalon read data and decoded TX frames are
// checked by monitors against expectation queues filled by the stimulus.
`timescale 1ns/1ps
module tb_uart_fifo;

  localparam int CPB = 16;
  localparam int DW  = 8;
`ifdef UART_FIFO_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FRAME = (DW + PB + 2) * CPB;

  logic        clk = 1'b0, rst = 1'b1;
  logic        avalon_read = 1'b0, avalon_write = 1'b0;
  logic [1:0]  avalon_address = 2'd0, avalon_byteenable = 2'b11;
  logic [15:0] avalon_writedata = 16'd0;
  logic [15:0] avalon_readdata;
  logic        avalon_waitrequest, status_irq, status_err, uart_txd;
  logic        loop_en = 1'b0, rxd_drv = 1'b1, tb_odd = 1'b0;
  wire         uart_rxd = loop_en ? uart_txd : rxd_drv;

  always #5 clk = ~clk;

  uart_fifo #(.CPB(CPB), .DW(DW), .TX_AW(3), .RX_AW(3)) dut (
    .clk(clk), .rst(rst),
    .avalon_read(avalon_read), .avalon_write(avalon_write),
    .avalon_address(avalon_address), .avalon_byteenable(avalon_byteenable),
    .avalon_writedata(avalon_writedata), .avalon_readdata(avalon_readdata),
    .avalon_waitrequest(avalon_waitrequest),
    .status_irq(status_irq), .status_err(status_err),
    .uart_rxd(uart_rxd), .uart_txd(uart_txd)
  );

  int          checks = 0, errors = 0, cyc = 0;
  logic [15:0] exp_rd_q[$];
  string       name_rd_q[$];
  logic [DW-1:0] exp_tx_q[$];
  int          tx_starts[$];
  logic        rd_seen = 1'b0;
`ifdef UART_FIFO_PARITY_EN
  logic        rx_par_flip = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else
      $display("ok   %s: 0x%0h", name, act);
  endtask

  // Read-data monitor: readdata is valid one cycle after the read strobe.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_seen <= avalon_read;
  end

  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexpected: got 0x%0h expected no read", avalon_readdata);
      end else
        chk(name_rd_q.pop_front(), avalon_readdata, exp_rd_q.pop_front());
    end
  end

  // Serial TX monitor: decodes each frame at bit centres.
  initial begin : tx_mon
    logic prev;
    logic [DW-1:0] b;
    prev = 1'b1;
    b = '0;
    forever begin
      @(negedge clk);
      if (prev && !uart_txd && !rst) begin
        tx_starts.push_back(cyc);
        repeat (CPB/2) @(negedge clk);
        chk("tx_start_bit", uart_txd, 0);
        for (int i = 0; i < DW; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = uart_txd;
        end
`ifdef UART_FIFO_PARITY_EN
        repeat (CPB) @(negedge clk);
        chk("tx_parity_bit", uart_txd, (^b) ^ tb_odd);
`endif
        repeat (CPB) @(negedge clk);
        chk("tx_stop_bit", uart_txd, 1);
        if (exp_tx_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected: got 0x%0h expected no frame", b);
        end else
          chk("tx_byte", b, exp_tx_q.pop_front());
      end
      prev = uart_txd;
    end
  end

  task automatic wr(input logic [1:0] a, input logic [15:0] d, output int stalls);
    @(negedge clk);
    avalon_write = 1'b1; avalon_address = a; avalon_writedata = d;
    stalls = 0;
    #1;
    while (avalon_waitrequest && stalls < 5000) begin
      @(negedge clk); #1;
      stalls++;
    end
    @(posedge clk); #1;
    avalon_write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [15:0] exp, input string n);
    @(negedge clk);
    avalon_read = 1'b1; avalon_address = a;
    exp_rd_q.push_back(exp); name_rd_q.push_back(n);
    @(negedge clk);
    avalon_read = 1'b0;
  endtask

  task automatic rx_frame(input logic [DW-1:0] b, input logic stop);
    @(negedge clk);
    rxd_drv = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < DW; i++) begin
      rxd_drv = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_FIFO_PARITY_EN
    rxd_drv = (^b) ^ tb_odd ^ rx_par_flip;
    repeat (CPB) @(negedge clk);
`endif
    rxd_drv = stop;
    repeat (CPB) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (2*CPB) @(negedge clk);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin : stim
    int st;
    repeat (3) @(negedge clk);
    chk("rst_txd", uart_txd, 1);
    chk("rst_readdata", avalon_readdata, 0);
    chk("rst_irq", status_irq, 0);
    chk("rst_err", status_err, 0);
    chk("rst_waitrequest", avalon_waitrequest, 0);
    rst = 1'b0;
    rd(2'd1, 16'h0004, "status_after_reset");

    // Single frame 0x55
    exp_tx_q.push_back(8'h55);
    wr(2'd0, 16'h0055, st);
    rd(2'd1, 16'h0000, "status_tx_busy");
    repeat (FRAME + 20) @(negedge clk);
    rd(2'd1, 16'h0004, "status_tx_done");

    // Nine back-to-back writes: the ninth stalls until the first frame ends
    tx_starts.delete();
    for (int i = 0; i < 9; i++) begin
      exp_tx_q.push_back(8'(8'h80 + i));
      wr(2'd0, 16'(16'h0080 + i), st);
      if (i == 7) chk("no_stall_8th", st, 0);
      if (i == 8) chk("stall_9th_in_range", (st >= FRAME - 20 && st <= FRAME + 5), 1);
    end
    repeat (8*FRAME + 40) @(negedge clk);
    chk("tx_frame_count", tx_starts.size(), 9);
    for (int i = 1; i < tx_starts.size(); i++)
      chk("tx_frame_spacing", tx_starts[i] - tx_starts[i-1], FRAME);
    rd(2'd1, 16'h0004, "status_after_burst");

    // Loopback 0xA3 with RX interrupt
    loop_en = 1'b1;
    wr(2'd2, 16'h0001, st);
    rd(2'd2, 16'h0001, "ctrl_readback");
    exp_tx_q.push_back(8'hA3);
    wr(2'd0, 16'h00A3, st);
    repeat (FRAME + 30) @(negedge clk);
    chk("irq_rx", status_irq, 1);
    rd(2'd1, 16'h0105, "status_rx_one");
    rd(2'd0, 16'h00A3, "data_A3");
    repeat (3) @(negedge clk);
    chk("irq_dropped", status_irq, 0);
    rd(2'd0, 16'h0000, "data_empty");

    // Nine loopback frames with no reads: overrun
    for (int i = 0; i < 9; i++) begin
      exp_tx_q.push_back(8'(8'h10 + i));
      wr(2'd0, 16'(16'h0010 + i), st);
    end
    repeat (8*FRAME + 60) @(negedge clk);
    rd(2'd1, 16'h0815, "status_overrun");
    chk("err_overrun", status_err, 1);
    wr(2'd1, 16'h0010, st);
    rd(2'd1, 16'h0805, "status_overrun_cleared");
    chk("err_cleared", status_err, 0);
    for (int i = 0; i < 8; i++) rd(2'd0, 16'(16'h0010 + i), "data_drain");
    rd(2'd1, 16'h0004, "status_drained");

    // Frame error, glitch, then a good manual frame
    loop_en = 1'b0;
    rx_frame(8'h5A, 1'b0);
    rd(2'd1, 16'h000C, "status_frame_err");
    chk("err_frame", status_err, 1);
    wr(2'd1, 16'h0008, st);
    rd(2'd1, 16'h0004, "status_frame_cleared");
    @(negedge clk);
    rxd_drv = 1'b0;
    repeat (CPB/4) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (3*CPB) @(negedge clk);
    rd(2'd1, 16'h0004, "status_after_glitch");
    chk("err_after_glitch", status_err, 0);
    rx_frame(8'h3C, 1'b1);
    rd(2'd1, 16'h0105, "status_rx_manual");
    rd(2'd0, 16'h003C, "data_3C");

`ifdef UART_FIFO_PARITY_EN
    tb_odd = 1'b1;
    wr(2'd2, 16'h0004, st);
    rd(2'd2, 16'h0004, "ctrl_parity_odd");
    exp_tx_q.push_back(8'h01);
    wr(2'd0, 16'h0001, st);
    repeat (FRAME + 20) @(negedge clk);
    rx_par_flip = 1'b1;
    rx_frame(8'h01, 1'b1);
    rx_par_flip = 1'b0;
    rd(2'd1, 16'h0125, "status_parity_err");
    chk("err_parity", status_err, 1);
    rd(2'd0, 16'h0001, "data_parity_byte");
    wr(2'd1, 16'h0020, st);
    rd(2'd1, 16'h0004, "status_parity_cleared");
`endif

    repeat (5) @(negedge clk);
    chk("rd_queue_empty", exp_rd_q.size(), 0);
    chk("tx_queue_empty", exp_tx_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
